hps_reset_req_sequencer: RTL
============================

Name: hps_reset_req_sequencer

Overview:
- Replaces the three independent per-type edge-to-pulse generators that drive the HPS cold, warm and debug reset-request inputs with one sequencer.
- Synchronises the three request levels from the HPS h2f reset-request bus and latches rising edges as pending requests.
- Grants pending requests one at a time in fixed priority and drives exactly one active-low reset-request pulse of per-type width, followed by a mandatory guard gap.
- Sits in the top level between the HPS h2f reset-request outputs and the f2h cold/warm/debug reset-request inputs, clocked by the 50 MHz FPGA clock.

Parameters:
- COLD_PULSE, 6: cold request pulse width in clk cycles (≥1)
- WARM_PULSE, 2: warm request pulse width in clk cycles (≥1)
- DEBUG_PULSE, 32: debug request pulse width in clk cycles (≥1)
- GUARD, 16: minimum idle cycles after every pulse (≥1)
- SYNC_STAGES, 2: synchroniser depth on req_in (≥2)
- CNT_WIDTH, 6: down-counter width; requires max(all pulse widths, GUARD) ≤ 2^CNT_WIDTH

Ports:
- clk  in  1  50 MHz clock
- rst_n  in  1  asynchronous active-low reset
- req_in  in  3  request levels: [0]=cold, [1]=warm, [2]=debug
- cold_req_n  out  1  registered active-low cold reset request
- warm_req_n  out  1  registered active-low warm reset request
- debug_req_n  out  1  registered active-low debug reset request
- grant  out  3  one-hot type currently pulsing; 0 otherwise
- pending  out  3  latched, not-yet-served requests
- busy  out  1  high in PULSE or GUARD

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous, active-low.
- Reset (asserted at any time, including mid-pulse):
  - all *_req_n=1, grant=0, pending=0, busy=0, state=IDLE, counter=0.
  - Synchroniser and edge-history flops reset to 1. A req_in level held high across reset is therefore not replayed; it must fall and rise again.
- Edge detect:
  - rise[i] = sync[i] & ~hist[i], where sync is the last synchroniser stage and hist is sync delayed one cycle.
  - A rise sets pending[i] on the next edge.
- Latency: req_in[i] rising, sampled at edge t0 with FSM in IDLE and nothing else pending -> pending[i]=1 at t0+SYNC_STAGES -> *_req_n low, grant and busy set at t0+SYNC_STAGES+1.
- FSM states:
  - IDLE: if pending≠0, grant the highest-priority bit (cold > warm > debug), clear that pending bit, load counter=width-1, go to PULSE.
  - PULSE: output low. If counter==0, deassert output, load counter=GUARD-1, go to GUARD; else decrement. Output is low for exactly width cycles.
  - GUARD: outputs high, grant=0, busy=1. If counter==0: go to PULSE with the next grant if pending≠0, else go to IDLE. Otherwise decrement.
- Simultaneous events:
  - Multiple rises in one cycle: all are latched and served in priority order.
  - A rise coinciding with the grant-clear of the same bit: the set wins, so the bit stays pending.
  - A rise of the type currently in PULSE is latched and served after the guard.
  - Repeated rises of an already-pending type coalesce into one request.
- Lower priority may starve while higher-priority rises keep arriving. This is accepted; the source rate is bounded by software.
- Counter never wraps: it is only decremented when non-zero and only loaded on state entry.
- At most one *_req_n is low at any time, and grant equals the bitwise inverse of the outputs.

Decomposition:
- Package hps_rst_pkg holds:
  - state encoding (IDLE, PULSE, GUARD)
  - index constants RST_COLD=0, RST_WARM=1, RST_DEBUG=2
  - a width-select function mapping grant index to pulse width minus one
- One sub-module: req_edge_sync, a per-bit SYNC_STAGES synchroniser plus rise detector with reset-to-1 history. It is instantiated with width 3.

Test Plan:
- Single cold: req_in=3'b001 rises at t0 -> cold_req_n low at t0+3 for exactly 6 cycles; busy low again at t0+3+6+16; pending=0 throughout, except the one cycle at t0+2.
- Simultaneous: req_in 000->111 at t0 -> cold pulse 6 cycles, guard 16, warm pulse 2, guard 16, debug pulse 32, guard 16. Grant sequence 001, 010, 100; never two outputs low at once.
- Re-request during own pulse: warm rises again mid-pulse -> second 2-cycle warm pulse starts immediately after the 16-cycle guard; three rises during one pulse yield exactly one extra pulse.
- Priority preemption of the queue: debug pending and warm rises during a cold pulse -> after the guard, warm is served before debug.
- Reset mid-pulse: rst_n low during cycle 10 of a debug pulse -> debug_req_n=1, busy=0, pending=0 asynchronously. With req_in held 100 through reset release, no pulse occurs; 100->000->100 then yields a normal 32-cycle pulse.
- Parameter corner: COLD_PULSE=1, GUARD=1 -> 1-cycle low pulse, 1-cycle guard; back-to-back cold rises 4 cycles apart give two distinct pulses.

Source files
------------

// File: rtl/hps_reset_req_sequencer_pkg.sv
// Shared types and helpers for the HPS reset-request sequencer: FSM encoding,
// reset-type indices and the per-type pulse-length lookup.
package hps_rst_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PULSE = 2'd1,
    ST_GUARD = 2'd2
  } state_t;

  localparam int unsigned RST_COLD  = 0;
  localparam int unsigned RST_WARM  = 1;
  localparam int unsigned RST_DEBUG = 2;
  localparam int unsigned RST_TYPES = 3;

  // Pulse width minus one, so the value can be loaded straight into the down-counter.
  function automatic int unsigned pulse_len_m1(
    input int unsigned idx,
    input int unsigned cold_w,
    input int unsigned warm_w,
    input int unsigned debug_w
  );
    if (idx == RST_COLD) begin
      return cold_w - 1;
    end else if (idx == RST_WARM) begin
      return warm_w - 1;
    end else begin
      return debug_w - 1;
    end
  endfunction

endpackage

// File: rtl/hps_reset_req_sequencer_if.sv
// Request/response bundle between the HPS h2f reset-request levels and the
// sequencer that drives the f2h reset-request pins.
interface hps_reset_req_sequencer_if;
  import hps_rst_pkg::*;

  logic [RST_TYPES-1:0] req_in;
  logic                 cold_req_n;
  logic                 warm_req_n;
  logic                 debug_req_n;
  logic [RST_TYPES-1:0] grant;
  logic [RST_TYPES-1:0] pending;
  logic                 busy;

  modport master (
    output req_in,
    input  cold_req_n, warm_req_n, debug_req_n, grant, pending, busy
  );

  modport slave (
    input  req_in,
    output cold_req_n, warm_req_n, debug_req_n, grant, pending, busy
  );

endinterface

// File: rtl/hps_reset_req_sequencer_req_edge_sync.sv
// Per-bit multi-stage synchroniser followed by a rising-edge detector.
// All flops reset to 1 so a level held high through reset is not seen as a rise.
module req_edge_sync #(
  parameter int unsigned WIDTH       = 3,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] rise
);

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      logic [SYNC_STAGES-1:0] sync_reg;
      logic                   hist_reg;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sync_reg <= '1;
          hist_reg <= 1'b1;
        end else begin
          sync_reg <= {sync_reg[SYNC_STAGES-2:0], d[gi]};
          hist_reg <= sync_reg[SYNC_STAGES-1];
        end
      end

      assign rise[gi] = sync_reg[SYNC_STAGES-1] & ~hist_reg;
    end
  endgenerate

endmodule

// File: rtl/hps_reset_req_sequencer.sv
// Latches cold/warm/debug reset-request edges and serves them one at a time in
// fixed priority as an active-low pulse of per-type width plus a guard gap.
module hps_reset_req_sequencer
  import hps_rst_pkg::*;
#(
  parameter int unsigned COLD_PULSE  = 6,
  parameter int unsigned WARM_PULSE  = 2,
  parameter int unsigned DEBUG_PULSE = 32,
  parameter int unsigned GUARD       = 16,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_WIDTH   = 6
) (
  input logic                      clk,
  input logic                      rst_n,
  hps_reset_req_sequencer_if.slave bus
);

  localparam logic [CNT_WIDTH-1:0] GUARD_M1 = CNT_WIDTH'(GUARD - 1);

  logic [RST_TYPES-1:0] rise;
  logic [RST_TYPES-1:0] pending_reg, pending_next;
  logic [RST_TYPES-1:0] grant_reg, grant_next;
  logic [RST_TYPES-1:0] req_n_reg;
  logic [RST_TYPES-1:0] clear_mask;
  logic [RST_TYPES-1:0] pick_oh;
  int unsigned          pick_idx;
  logic [CNT_WIDTH-1:0] pick_len;
  logic [CNT_WIDTH-1:0] cnt_reg, cnt_next;
  logic                 busy_reg;
  state_t               state_reg, state_next;

  req_edge_sync #(
    .WIDTH       (RST_TYPES),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_req_edge_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (bus.req_in),
    .rise  (rise)
  );

  // Fixed priority: cold > warm > debug.
  always_comb begin
    pick_oh  = '0;
    pick_idx = RST_COLD;
    if (pending_reg[RST_COLD]) begin
      pick_oh[RST_COLD] = 1'b1;
      pick_idx          = RST_COLD;
    end else if (pending_reg[RST_WARM]) begin
      pick_oh[RST_WARM] = 1'b1;
      pick_idx          = RST_WARM;
    end else if (pending_reg[RST_DEBUG]) begin
      pick_oh[RST_DEBUG] = 1'b1;
      pick_idx           = RST_DEBUG;
    end
    pick_len = CNT_WIDTH'(pulse_len_m1(pick_idx, COLD_PULSE, WARM_PULSE, DEBUG_PULSE));
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    grant_next = grant_reg;
    clear_mask = '0;
    case (state_reg)
      ST_IDLE: begin
        if (|pending_reg) begin
          state_next = ST_PULSE;
          grant_next = pick_oh;
          clear_mask = pick_oh;
          cnt_next   = pick_len;
        end
      end
      ST_PULSE: begin
        if (cnt_reg == '0) begin
          state_next = ST_GUARD;
          grant_next = '0;
          cnt_next   = GUARD_M1;
        end else begin
          cnt_next = cnt_reg - CNT_WIDTH'(1);
        end
      end
      ST_GUARD: begin
        if (cnt_reg == '0) begin
          if (|pending_reg) begin
            state_next = ST_PULSE;
            grant_next = pick_oh;
            clear_mask = pick_oh;
            cnt_next   = pick_len;
          end else begin
            state_next = ST_IDLE;
          end
        end else begin
          cnt_next = cnt_reg - CNT_WIDTH'(1);
        end
      end
      default: begin
        state_next = ST_IDLE;
        grant_next = '0;
        cnt_next   = '0;
      end
    endcase
  end

  // A new rise wins over the clear of the bit being granted in the same cycle.
  assign pending_next = (pending_reg & ~clear_mask) | rise;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= ST_IDLE;
      cnt_reg     <= '0;
      grant_reg   <= '0;
      pending_reg <= '0;
      req_n_reg   <= '1;
      busy_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      grant_reg   <= grant_next;
      pending_reg <= pending_next;
      req_n_reg   <= ~grant_next;
      busy_reg    <= (state_next != ST_IDLE);
    end
  end

  assign bus.cold_req_n  = req_n_reg[RST_COLD];
  assign bus.warm_req_n  = req_n_reg[RST_WARM];
  assign bus.debug_req_n = req_n_reg[RST_DEBUG];
  assign bus.grant       = grant_reg;
  assign bus.pending     = pending_reg;
  assign bus.busy        = busy_reg;

endmodule
